lane_count_bank: RTL

- Bank of NUM_LANE independent per-lane event counters, one counter per generate iteration.
- Each counter resets to its own lane index.
- Generalises the lane-indexed assignment pattern: adds per-lane increment, wrap/saturate mode, synchronous clear, and a snapshot-and-stream readout over a valid/ready handshake.
- Sits beside lane-parallel datapaths as a statistics/debug collector.

---
 rtl/lane_count_bank.sv | 109 ++++++++++
 1 files changed

// File: rtl/lane_count_bank.sv
// Bank of per-lane event counters, each resetting to its own lane index,
// with a snapshot that is streamed out one lane per beat over valid/ready.
module lane_count_bank #(
  parameter int NUM_LANE  = 10,
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255,
  parameter bit SATURATE  = 1'b0,
  localparam int LANE_W   = $clog2(NUM_LANE)
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_clr,
  input  logic [NUM_LANE-1:0]       i_inc,
  input  logic                      i_snap,
  output logic                      o_busy,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [LANE_W-1:0]         o_lane,
  output logic [WIDTH-1:0]          o_count,
  output logic                      o_last,
  output logic [NUM_LANE*WIDTH-1:0] o_counts
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  localparam logic [WIDTH-1:0]  MAX_VAL  = WIDTH'(MAX_COUNT);
  localparam logic [LANE_W-1:0] LAST_PTR = LANE_W'(NUM_LANE - 1);

  logic [0:0]        state;
  logic [LANE_W-1:0] ptr;
  logic              take_snap;
  logic              at_last;
  logic [WIDTH-1:0]  snap_bus [NUM_LANE];

  assign take_snap = (state == IDLE) && i_snap;
  assign at_last   = (ptr == LAST_PTR);

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    localparam logic [WIDTH-1:0] IDX = WIDTH'(g);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] snap;

    // Clear outranks increment; the terminal count either wraps or sticks.
    always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
        cnt <= IDX;
      end else if (i_clr) begin
        cnt <= IDX;
      end else if (i_inc[g]) begin
        if (cnt == MAX_VAL) begin
          cnt <= SATURATE ? MAX_VAL : '0;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
        snap <= '0;
      end else if (take_snap) begin
        snap <= cnt;
      end
    end

    assign o_counts[g*WIDTH +: WIDTH] = cnt;
    assign snap_bus[g]                = snap;
  end

  // Snapshot requests arriving mid-stream are dropped rather than queued.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_snap) begin
            state <= STREAM;
            ptr   <= '0;
          end
        end
        STREAM: begin
          if (i_ready) begin
            if (at_last) begin
              state <= IDLE;
              ptr   <= '0;
            end else begin
              ptr <= ptr + LANE_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign o_busy  = (state == STREAM);
  assign o_valid = (state == STREAM);
  assign o_lane  = (state == STREAM) ? ptr : '0;
  assign o_count = (state == STREAM) ? snap_bus[ptr] : '0;
  assign o_last  = (state == STREAM) && at_last;

endmodule
